// File: rtl/regfile_be.sv
// regfile_be -- 2**ADDR_W x WIDTH register file with per-byte write enables.
//
// Ports:
//   clk              rising-edge clock; the only source of state change
//   rst              synchronous active-high reset: data <= RESET_VAL, valid <= 0
//   set              synchronous active-high preset: data <= all-ones, valid <= 1
//   we/waddr/wbe/wdata  write port; wbe[i] enables byte lane wdata[8i+7:8i]
//   raddr0/rdata0/rvalid0  combinational read port 0
//   raddr1/rdata1/rvalid1  combinational read port 1
//
// Edge priority is rst > set > write. A write with wbe == 0 changes nothing,
// including the valid bit. With BYPASS=1 a qualifying write is forwarded
// (byte-merged with the stored entry) to any read port addressing it in the
// same cycle; forwarding is off while rst or set is asserted.

module regfile_be #(
  parameter int unsigned          WIDTH     = 32,
  parameter int unsigned          ADDR_W    = 3,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  parameter bit                   BYPASS    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [WIDTH/8-1:0]      wbe,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [ADDR_W-1:0]       raddr0,
  output logic [WIDTH-1:0]        rdata0,
  output logic                    rvalid0,
  input  logic [ADDR_W-1:0]       raddr1,
  output logic [WIDTH-1:0]        rdata1,
  output logic                    rvalid1
);

  localparam int unsigned NB    = WIDTH / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;

  // Byte-enable vector expanded to a bit mask so merges are a simple and/or.
  logic [WIDTH-1:0] bmask;
  logic             wr_any;
  logic             fwd_en;

  for (genvar b = 0; b < NB; b++) begin : g_mask
    assign bmask[8*b +: 8] = {8{wbe[b]}};
  end

  assign wr_any = we && (|wbe);
  assign fwd_en = BYPASS && wr_any && !rst && !set;

  // One register process per entry keeps every index a constant.
  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        mem[e]   <= RESET_VAL;
        valid[e] <= 1'b0;
      end else if (set) begin
        mem[e]   <= '1;
        valid[e] <= 1'b1;
      end else if (wr_any && (waddr == ADDR_W'(e))) begin
        mem[e]   <= (mem[e] & ~bmask) | (wdata & bmask);
        valid[e] <= 1'b1;
      end
    end
  end

  always_comb begin
    rdata0  = mem[raddr0];
    rvalid0 = valid[raddr0];
    if (fwd_en && (raddr0 == waddr)) begin
      rdata0  = (mem[raddr0] & ~bmask) | (wdata & bmask);
      rvalid0 = 1'b1;
    end
  end

  always_comb begin
    rdata1  = mem[raddr1];
    rvalid1 = valid[raddr1];
    if (fwd_en && (raddr1 == waddr)) begin
      rdata1  = (mem[raddr1] & ~bmask) | (wdata & bmask);
      rvalid1 = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_be.sv
// Testbench for regfile_be: one instance with forwarding, one without, driven
// by the same inputs. Directed table rows, then randomized cycles checked
// against an array-based reference model.

module tb_regfile_be;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, set, we;
  logic [2:0]  waddr, raddr0, raddr1;
  logic [3:0]  wbe;
  logic [31:0] wdata;

  logic [31:0] b_rdata0, b_rdata1, n_rdata0, n_rdata1;
  logic        b_rvalid0, b_rvalid1, n_rvalid0, n_rvalid1;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [DEPTH];
  bit          m_v   [DEPTH];

  always #5 clk = ~clk;

  regfile_be #(.WIDTH(32), .ADDR_W(3), .RESET_VAL(32'h0000_0000), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .set(set), .we(we), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .raddr0(raddr0), .rdata0(b_rdata0), .rvalid0(b_rvalid0),
    .raddr1(raddr1), .rdata1(b_rdata1), .rvalid1(b_rvalid1)
  );

  regfile_be #(.WIDTH(32), .ADDR_W(3), .RESET_VAL(32'h0000_0000), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst(rst), .set(set), .we(we), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .raddr0(raddr0), .rdata0(n_rdata0), .rvalid0(n_rvalid0),
    .raddr1(raddr1), .rdata1(n_rdata1), .rvalid1(n_rvalid1)
  );

  typedef struct {
    logic        rst, set, we;
    logic [2:0]  waddr;
    logic [3:0]  wbe;
    logic [31:0] wdata;
    logic [2:0]  ra0, ra1;
    logic [31:0] bd0; logic bv0; logic [31:0] bd1; logic bv1;
    logic [31:0] nd0; logic nv0; logic [31:0] nd1; logic nv1;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic w, input logic [2:0] wa,
                       input logic [3:0] be, input logic [31:0] wd,
                       input logic [2:0] a0, input logic [2:0] a1);
    rst = r; set = s; we = w; waddr = wa; wbe = be; wdata = wd; raddr0 = a0; raddr1 = a1;
  endtask

  // Reference read: stored entry, overlaid byte-by-byte with a same-cycle write
  // when forwarding applies.
  task automatic model_read(input bit byp, input logic [2:0] ra,
                            output logic [31:0] d, output logic v);
    d = m_mem[ra];
    v = m_v[ra];
    if (byp && we && !rst && !set && wbe != 4'b0 && ra == waddr) begin
      for (int i = 0; i < 4; i++)
        if (wbe[i]) d[8*i +: 8] = wdata[8*i +: 8];
      v = 1'b1;
    end
  endtask

  // Advance one clock edge and apply the same edge to the reference model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin m_mem[e] = 32'h0; m_v[e] = 1'b0; end
    end else if (set) begin
      for (int e = 0; e < DEPTH; e++) begin m_mem[e] = 32'hFFFF_FFFF; m_v[e] = 1'b1; end
    end else if (we && wbe != 4'b0) begin
      for (int i = 0; i < 4; i++)
        if (wbe[i]) m_mem[waddr][8*i +: 8] = wdata[8*i +: 8];
      m_v[waddr] = 1'b1;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] d; logic v;
    model_read(1'b1, raddr0, d, v);
    chk({tag, " byp rdata0"}, b_rdata0, d);  chk({tag, " byp rvalid0"}, {31'b0, b_rvalid0}, {31'b0, v});
    model_read(1'b1, raddr1, d, v);
    chk({tag, " byp rdata1"}, b_rdata1, d);  chk({tag, " byp rvalid1"}, {31'b0, b_rvalid1}, {31'b0, v});
    model_read(1'b0, raddr0, d, v);
    chk({tag, " nob rdata0"}, n_rdata0, d);  chk({tag, " nob rvalid0"}, {31'b0, n_rvalid0}, {31'b0, v});
    model_read(1'b0, raddr1, d, v);
    chk({tag, " nob rdata1"}, n_rdata1, d);  chk({tag, " nob rvalid1"}, {31'b0, n_rvalid1}, {31'b0, v});
  endtask

  initial begin
    //          rst  set  we   wa  wbe      wdata          ra0 ra1  bd0           bv0  bd1           bv1  nd0           nv0  nd1           nv1
    tbl[0]  = '{1'b0,1'b0,1'b1,3'd5,4'b1111,32'hDEAD_BEEF,3'd5,3'd4,32'hDEAD_BEEF,1'b1,32'h0,       1'b0,32'h0,       1'b0,32'h0,       1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b0,3'd0,4'b0000,32'h0,        3'd5,3'd4,32'hDEAD_BEEF,1'b1,32'h0,       1'b0,32'hDEAD_BEEF,1'b1,32'h0,      1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b1,3'd2,4'b1111,32'h1122_3344,3'd2,3'd5,32'h1122_3344,1'b1,32'hDEAD_BEEF,1'b1,32'h0,      1'b0,32'hDEAD_BEEF,1'b1};
    tbl[3]  = '{1'b0,1'b0,1'b1,3'd2,4'b0101,32'hAABB_CCDD,3'd2,3'd2,32'h11BB_33DD,1'b1,32'h11BB_33DD,1'b1,32'h1122_3344,1'b1,32'h1122_3344,1'b1};
    tbl[4]  = '{1'b0,1'b0,1'b0,3'd0,4'b0000,32'h0,        3'd2,3'd3,32'h11BB_33DD,1'b1,32'h0,       1'b0,32'h11BB_33DD,1'b1,32'h0,      1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b1,3'd3,4'b1111,32'h0000_00FF,3'd3,3'd6,32'h0000_00FF,1'b1,32'h0,       1'b0,32'h0,       1'b0,32'h0,       1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b1,3'd3,4'b0010,32'h0000_AB00,3'd3,3'd3,32'h0000_ABFF,1'b1,32'h0000_ABFF,1'b1,32'h0000_00FF,1'b1,32'h0000_00FF,1'b1};
    tbl[7]  = '{1'b0,1'b0,1'b0,3'd0,4'b0000,32'h0,        3'd3,3'd1,32'h0000_ABFF,1'b1,32'h0,       1'b0,32'h0000_ABFF,1'b1,32'h0,      1'b0};
    tbl[8]  = '{1'b1,1'b1,1'b1,3'd1,4'b1111,32'h5555_5555,3'd1,3'd3,32'h0,        1'b0,32'h0000_ABFF,1'b1,32'h0,      1'b0,32'h0000_ABFF,1'b1};
    tbl[9]  = '{1'b0,1'b1,1'b1,3'd1,4'b1111,32'h1234_5678,3'd1,3'd3,32'h0,        1'b0,32'h0,       1'b0,32'h0,       1'b0,32'h0,       1'b0};
    tbl[10] = '{1'b0,1'b0,1'b0,3'd0,4'b0000,32'h0,        3'd1,3'd6,32'hFFFF_FFFF,1'b1,32'hFFFF_FFFF,1'b1,32'hFFFF_FFFF,1'b1,32'hFFFF_FFFF,1'b1};
    tbl[11] = '{1'b1,1'b0,1'b0,3'd0,4'b0000,32'h0,        3'd0,3'd7,32'hFFFF_FFFF,1'b1,32'hFFFF_FFFF,1'b1,32'hFFFF_FFFF,1'b1,32'hFFFF_FFFF,1'b1};
    tbl[12] = '{1'b0,1'b0,1'b1,3'd6,4'b0000,32'hCAFE_F00D,3'd6,3'd6,32'h0,        1'b0,32'h0,       1'b0,32'h0,       1'b0,32'h0,       1'b0};
    tbl[13] = '{1'b0,1'b0,1'b0,3'd0,4'b0000,32'h0,        3'd6,3'd0,32'h0,        1'b0,32'h0,       1'b0,32'h0,       1'b0,32'h0,       1'b0};

    // Initial reset edge; contents are undefined before it.
    drive(1'b1, 1'b0, 1'b0, 3'd0, 4'b0, 32'h0, 3'd0, 3'd0);
    tick();

    // Reset sweep over every address on both ports.
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 1'b0, 1'b0, 3'd0, 4'b0, 32'h0, 3'(a), 3'(7 - a));
      #3;
      chk($sformatf("reset rdata0[%0d]", a), b_rdata0, 32'h0);
      chk($sformatf("reset rvalid0[%0d]", a), {31'b0, b_rvalid0}, 32'h0);
      chk($sformatf("reset rdata1[%0d]", 7 - a), n_rdata1, 32'h0);
      chk($sformatf("reset rvalid1[%0d]", 7 - a), {31'b0, n_rvalid1}, 32'h0);
      tick();
    end

    // Directed rows: outputs checked mid-cycle, before the row's own edge.
    for (int r = 0; r < 14; r++) begin
      drive(tbl[r].rst, tbl[r].set, tbl[r].we, tbl[r].waddr, tbl[r].wbe, tbl[r].wdata,
            tbl[r].ra0, tbl[r].ra1);
      #3;
      chk($sformatf("row%0d byp rdata0", r),  b_rdata0, tbl[r].bd0);
      chk($sformatf("row%0d byp rvalid0", r), {31'b0, b_rvalid0}, {31'b0, tbl[r].bv0});
      chk($sformatf("row%0d byp rdata1", r),  b_rdata1, tbl[r].bd1);
      chk($sformatf("row%0d byp rvalid1", r), {31'b0, b_rvalid1}, {31'b0, tbl[r].bv1});
      chk($sformatf("row%0d nob rdata0", r),  n_rdata0, tbl[r].nd0);
      chk($sformatf("row%0d nob rvalid0", r), {31'b0, n_rvalid0}, {31'b0, tbl[r].nv0});
      chk($sformatf("row%0d nob rdata1", r),  n_rdata1, tbl[r].nd1);
      chk($sformatf("row%0d nob rvalid1", r), {31'b0, n_rvalid1}, {31'b0, tbl[r].nv1});
      tick();
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [2:0] wa;
      logic [3:0] be;
      wa = 3'($urandom_range(0, 7));
      be = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 15) == 0, 1'($urandom), wa, be, $urandom,
            ($urandom_range(0, 1) == 0) ? wa : 3'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 0) ? wa : 3'($urandom_range(0, 7)));
      #3;
      check_model($sformatf("rand%0d", n));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_be.md
Name: regfile_be

Overview:
- Parametrised successor to the team's fixed 8-bit register primitive.
- A 2^ADDR_W-entry by WIDTH-bit register file with:
  - one synchronous write port with per-byte write enables
  - two combinational read ports
  - a per-entry valid bit
  - global synchronous set and reset
  - optional write-to-read forwarding
- Serves as the architectural/temporary register storage for datapath stages; replaces banks of hand-instanced 8-bit registers.

Parameters:
WIDTH, 32, data width in bits; must be a multiple of 8 (NB = WIDTH/8 byte lanes)
ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries
RESET_VAL, 0, value (WIDTH bits) loaded into every entry on reset
BYPASS, 1, 1 = a write in the current cycle is forwarded to matching read ports; 0 = reads see stored data only

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
set  input  1  synchronous active-high preset: all entries to all-ones, all valid
we  input  1  write enable
waddr  input  ADDR_W  write address
wbe  input  NB  byte write enables; bit i covers wdata[8i+7:8i]
wdata  input  WIDTH  write data
raddr0  input  ADDR_W  read port 0 address
rdata0  output  WIDTH  read port 0 data
rvalid0  output  1  valid bit of entry raddr0 (after forwarding)
raddr1  input  ADDR_W  read port 1 address
rdata1  output  WIDTH  read port 1 data
rvalid1  output  1  valid bit of entry raddr1 (after forwarding)

Behaviour:
- State: DEPTH x WIDTH data array plus DEPTH valid bits. Only clk edges change state; no asynchronous paths.
- Per-edge priority is rst > set > write.
  - rst=1: every entry <= RESET_VAL and every valid <= 0. set and we are ignored.
  - rst=0, set=1: every entry <= all-ones and every valid <= 1. we is ignored.
  - rst=0, set=0, we=1: for each lane i with wbe[i]=1, entry[waddr] lane i <= wdata lane i. Lanes with wbe[i]=0 hold their value.
    - valid[waddr] <= 1 if any wbe bit is 1.
    - we=1 with wbe=0 is a no-op; valid is unchanged.
  - Otherwise all state holds.
- Reads are combinational with zero latency; each port indexes the array independently. Both ports may address the same entry.
- Without forwarding, a write becomes visible at the read ports on the cycle after the edge.
- BYPASS=1, and all of we=1, rst=0, set=0, raddrN==waddr, wbe!=0:
  - rdataN = merge: lane i from wdata where wbe[i]=1, else the stored lane.
  - rvalidN = 1.
- Forwarding is suppressed while rst or set is high; those cycles show stored contents.
- BYPASS=0: rdataN/rvalidN always reflect stored state.
- Reset values of outputs:
  - After any reset edge: rdataN = RESET_VAL and rvalidN = 0 for all addresses.
  - After a set edge: rdataN = all-ones and rvalidN = 1.
- Reset applied mid-sequence discards any write presented in the same cycle. The write is not retained or replayed.
- Out-of-range addresses cannot occur (DEPTH = 2**ADDR_W).
- No X propagation from unwritten entries; every entry is defined after the first rst edge.
- Contents before the first rst edge are undefined. The bench must apply rst for at least one edge before checking.

Test Plan:
- Reset (WIDTH=32, ADDR_W=3, RESET_VAL=0x0000_0000): assert rst for 1 edge, then sweep raddr0/raddr1 over 0..7 -> rdata=0x0000_0000, rvalid=0 on every address.
- Full write with BYPASS=0: we=1, waddr=5, wbe=4'b1111, wdata=0xDEAD_BEEF. Same cycle raddr0=5 -> rdata0=0x0000_0000, rvalid0=0. Next cycle -> rdata0=0xDEAD_BEEF, rvalid0=1; raddr1=4 -> rvalid1=0.
- Byte-enable merge: entry 2 holds 0x1122_3344; write wbe=4'b0101, wdata=0xAABB_CCDD -> entry 2 reads 0x11BB_33DD next cycle.
- Forwarding with BYPASS=1: entry 3 holds 0x0000_00FF; in one cycle we=1, waddr=3, wbe=4'b0010, wdata=0x0000_AB00, raddr0=raddr1=3 -> both ports show 0x0000_ABFF and rvalid=1 in that same cycle, and entry 3 holds 0x0000_ABFF afterwards.
- Priority: cycle with rst=1, set=1, we=1 (waddr=1, wdata=0x5555_5555) -> all entries 0x0000_0000, valid=0, forwarding suppressed. Next cycle set=1 only -> all entries 0xFFFF_FFFF, valid=1.
- No-op write: we=1, wbe=0, waddr=6 on reset state -> entry 6 stays 0x0000_0000 with rvalid=0, and the forwarded read also shows rvalid=0.
